// File: rtl/stream_src_pkg.sv
// Shared types and constants for the stream packet source.
// Widths, FSM/pattern enums and the LFSR step used by the data generator.
package stream_src_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int GAP_W_DEF  = 8;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_TAG   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Right-shifting Galois step; taps 32,22,2,1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/stream_src_datagen.sv
// Pattern register for the packet source: loads seed/mode on start and
// steps only when a beat is transferred.
module stream_src_datagen
    import stream_src_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic        load,
    input  logic [31:0] seed,
    input  mode_e       mode,
    input  logic        advance,
    input  logic [15:0] pkt_idx,
    input  logic [15:0] word_idx,
    output logic [31:0] word
);

    mode_e       mode_q, mode_d;
    logic [31:0] pat_q, pat_d;

    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        if (load) begin
            mode_d = mode;
            // An all-zero LFSR state would lock up.
            pat_d  = (mode == MODE_LFSR && seed == 32'h0) ? 32'h1 : seed;
        end else if (advance) begin
            case (mode_q)
                MODE_CNT:  pat_d = pat_q + 32'h1;
                MODE_LFSR: pat_d = lfsr_next(pat_q);
                default:   pat_d = pat_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            mode_q <= MODE_CNT;
            pat_q  <= 32'h0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
        end
    end

    assign word = (mode_q == MODE_TAG) ? {pkt_idx, word_idx} : pat_q;

endmodule

// File: rtl/stream_packet_source.sv
// Valid/ready/last packet transmitter: N packets of L words with an idle
// gap between packets, sink backpressure and abort at a beat boundary.
module stream_packet_source
    import stream_src_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_npkt,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_mode,
    input  logic [31:0]       cfg_seed,
    output logic              valid,
    output logic              last,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_sent
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] npkt_q, npkt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] pkt_sent_q, pkt_sent_d;

    logic load;
    logic xfer;
    logic is_last;
    logic abort_pend;

    assign valid      = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done       = (state_q == ST_FIN);
    assign xfer       = valid & ready;
    assign is_last    = (word_idx_q == len_q - LEN_W'(1));
    assign last       = valid & is_last;
    assign abort_pend = abort & busy;
    assign pkt_sent   = pkt_sent_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        npkt_d     = npkt_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        word_idx_d = word_idx_q;
        pkt_sent_d = pkt_sent_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    npkt_d     = cfg_npkt;
                    gap_d      = cfg_gap;
                    word_idx_d = '0;
                    pkt_sent_d = '0;
                    load       = 1'b1;
                    state_d    = (cfg_npkt == '0) ? ST_FIN : ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        word_idx_d = '0;
                        pkt_sent_d = pkt_sent_q + CNT_W'(1);
                        if (pkt_sent_q + CNT_W'(1) == npkt_q) begin
                            state_d = ST_FIN;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        word_idx_d = word_idx_q + LEN_W'(1);
                    end
                end
                // A beat accepted alongside abort still counts; nothing follows it.
                if (abort_pend) begin
                    state_d = ST_FIN;
                end
            end
            ST_GAP: begin
                if (abort_pend) begin
                    state_d = ST_FIN;
                end else if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            npkt_q     <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            word_idx_q <= '0;
            pkt_sent_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            npkt_q     <= npkt_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            word_idx_q <= word_idx_d;
            pkt_sent_q <= pkt_sent_d;
        end
    end

    stream_src_datagen u_datagen (
        .clk      (clk),
        .rstb     (rstb),
        .load     (load),
        .seed     (cfg_seed),
        .mode     (mode_e'(cfg_mode)),
        .advance  (xfer),
        .pkt_idx  (pkt_sent_q[15:0]),
        .word_idx (word_idx_q[15:0]),
        .word     (dout)
    );

endmodule

// File: tb/tb_stream_packet_source.sv
// Scoreboard bench for stream_packet_source: expected beats come from a
// behavioural pattern model; a negedge monitor pops and compares transfers.
module tb_stream_packet_source;

    logic        clk = 1'b0;
    logic        rstb, start, abort, ready;
    logic [15:0] cfg_len, cfg_npkt;
    logic [7:0]  cfg_gap;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_seed;
    logic        valid, last, busy, done;
    logic [31:0] dout;
    logic [15:0] pkt_sent;

    always #5 clk = ~clk;

    stream_packet_source dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .abort    (abort),
        .cfg_len  (cfg_len),
        .cfg_npkt (cfg_npkt),
        .cfg_gap  (cfg_gap),
        .cfg_mode (cfg_mode),
        .cfg_seed (cfg_seed),
        .valid    (valid),
        .last     (last),
        .ready    (ready),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .pkt_sent (pkt_sent)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    ready_mode = 0;   // 0 tied high, 1 pattern 1,0,0,1, 2 random, 3 manual
    logic  ready_man = 1'b1;
    int    cur_gap = 0;
    bit    abort_run = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if ((s & 32'h1) != 0) n = n ^ 32'h80200003;
        return n;
    endfunction

    int ph = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = (ph == 0 || ph == 3);
            2:       ready = ($urandom_range(0, 1) == 1);
            default: ready = ready_man;
        endcase
        ph = (ph + 1) % 4;
    end

    bit          stall_q = 1'b0;
    logic [31:0] stall_d;
    logic        stall_l;
    bit          gap_trk = 1'b0;
    int          gap_seen = 0;

    always @(negedge clk) begin
        if (!rstb) begin
            if (stall_q && valid) begin
                check("stall_dout", dout, stall_d);
                check("stall_last", last, stall_l);
            end else if (stall_q && !abort_run) begin
                check("stall_valid_held", valid, 1);
            end
            if (gap_trk) begin
                if (valid) begin
                    check("gap_len", gap_seen, cur_gap);
                    gap_trk = 1'b0;
                end else if (busy) begin
                    gap_seen++;
                end else begin
                    gap_trk = 1'b0;
                end
            end
            stall_q = valid && !ready;
            stall_d = dout;
            stall_l = last;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_beat: got dout 0x%0h last %0d, required no beat", dout, last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_dout", dout, e.d);
                    check("beat_last", last, e.l);
                    if (last) begin
                        gap_trk  = 1'b1;
                        gap_seen = 0;
                    end
                end
            end
        end
    end

    task automatic push_model(input int len, input int npkt, input int mode,
                              input logic [31:0] seed, input int nbeats);
        int          el;
        int          k;
        logic [31:0] s;
        logic [31:0] d;
        el = (len == 0) ? 1 : len;
        s  = (mode == 1 && seed == 0) ? 32'h1 : seed;
        k  = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int w = 0; w < el; w++) begin
                case (mode)
                    0:       d = seed + 32'(k);
                    1:       d = s;
                    2:       d = seed;
                    default: d = {16'(p), 16'(w)};
                endcase
                s = model_lfsr(s);
                if (k < nbeats) exp_q.push_back('{d: d, l: (w == el - 1)});
                k++;
            end
        end
    endtask

    task automatic run(input int len, input int npkt, input int gap, input int mode,
                       input logic [31:0] seed, input int abort_at, input bit abort_rdy,
                       input bit start_abort, input int rmode);
        int el;
        int nbeats;
        int exp_pkts;
        int cyc;
        el       = (len == 0) ? 1 : len;
        nbeats   = el * npkt;
        exp_pkts = npkt;
        if (abort_at > 0) begin
            nbeats   = abort_rdy ? abort_at : abort_at - 1;
            exp_pkts = nbeats / el;
        end
        exp_q.delete();
        push_model(len, npkt, mode, seed, nbeats);
        cur_gap    = gap;
        abort_run  = (abort_at > 0);
        ready_mode = rmode;
        ready_man  = 1'b1;

        @(posedge clk);
        #1;
        cfg_len  = 16'(len);
        cfg_npkt = 16'(npkt);
        cfg_gap  = 8'(gap);
        cfg_mode = 2'(mode);
        cfg_seed = seed;
        start    = 1'b1;
        abort    = start_abort;
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_len  = 16'($urandom);
        cfg_npkt = 16'($urandom);
        cfg_gap  = 8'($urandom);
        cfg_mode = 2'($urandom);
        cfg_seed = $urandom;
        @(negedge clk);
        if (npkt > 0) check("first_beat_latency", valid, 1);

        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            ready_man = abort_rdy;
            #1 abort = 1'b1;
            @(posedge clk);
            ready_man = 1'b1;
            #1 abort = 1'b0;
            @(negedge clk);
            check("abort_valid_drop", valid, 0);
            check("abort_no_last", last, 0);
        end

        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
        end else begin
            if (npkt == 0) check("npkt0_done_latency", (cyc <= 1), 1);
            else if (rmode == 0 && abort_at == 0)
                check("done_latency", cyc, el * npkt + gap * (npkt - 1));
            check("pkt_sent", pkt_sent, exp_pkts);
            check("beats_outstanding", exp_q.size(), 0);
            check("busy_at_done", busy, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
        abort_run = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rstb     = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        ready    = 1'b1;
        cfg_len  = '0;
        cfg_npkt = '0;
        cfg_gap  = '0;
        cfg_mode = '0;
        cfg_seed = '0;
        #12;
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_pkt_sent", pkt_sent, 0);
        @(posedge clk);
        #1 rstb = 1'b0;

        // abort in IDLE must do nothing
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);

        run(4, 2, 0, 0, 32'h10, 0, 1'b0, 1'b0, 0);
        run(4, 2, 0, 0, 32'h10, 0, 1'b0, 1'b0, 1);
        run(3, 2, 5, 3, 32'h0, 0, 1'b0, 1'b0, 0);
        run(3, 1, 0, 1, 32'h0, 0, 1'b0, 1'b0, 0);
        run(8, 1, 0, 0, 32'h100, 3, 1'b0, 1'b0, 3);
        run(8, 1, 0, 0, 32'h100, 3, 1'b1, 1'b0, 3);
        run(5, 0, 2, 0, 32'h55, 0, 1'b0, 1'b0, 0);
        run(2, 2, 1, 2, 32'hCAFEBABE, 0, 1'b0, 1'b1, 2);
        run(0, 3, 0, 0, 32'hFFFFFFFE, 0, 1'b0, 1'b0, 0);

        // reset mid-packet, then replay from the seed
        ready_mode = 0;
        @(posedge clk);
        #1;
        cfg_len  = 16'd8;
        cfg_npkt = 16'd1;
        cfg_gap  = 8'd0;
        cfg_mode = 2'd0;
        cfg_seed = 32'h200;
        push_model(8, 1, 0, 32'h200, 8);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstb = 1'b1;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dout", dout, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rstb = 1'b0;
        run(8, 1, 0, 0, 32'h200, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, 0, 1'b0, 1'b0, 2);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
